// File: rtl/hilo_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: op codes, FSM states, default width.
// The divider is only built when HILO_DIV_EN is defined.
package hilo_pkg;

  localparam int HILO_DATA_W = 32;

  localparam logic [2:0] HILO_OP_MULT  = 3'd0;
  localparam logic [2:0] HILO_OP_MULTU = 3'd1;
  localparam logic [2:0] HILO_OP_DIV   = 3'd2;
  localparam logic [2:0] HILO_OP_DIVU  = 3'd3;
  localparam logic [2:0] HILO_OP_MTHI  = 3'd4;
  localparam logic [2:0] HILO_OP_MTLO  = 3'd5;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_FIX  = 2'd3
  } hilo_state_e;

  function automatic logic hilo_op_signed(input logic [2:0] op);
    return (op == HILO_OP_MULT) || (op == HILO_OP_DIV);
  endfunction

  function automatic logic hilo_op_mul(input logic [2:0] op);
    return (op == HILO_OP_MULT) || (op == HILO_OP_MULTU);
  endfunction

  function automatic logic hilo_op_mt(input logic [2:0] op);
    return (op == HILO_OP_MTHI) || (op == HILO_OP_MTLO);
  endfunction

endpackage

// File: rtl/hilo_iter_core.sv
// Shared one-bit-per-cycle datapath: shift-add multiply and (with HILO_DIV_EN) restoring divide.
// Operands are unsigned magnitudes; sign handling lives in the top level.
module hilo_iter_core
  import hilo_pkg::*;
#(
  parameter int W = HILO_DATA_W
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           i_start,
  input  logic           i_step,
`ifdef HILO_DIV_EN
  input  logic           i_mode,
  output logic [W-1:0]   o_quot,
  output logic [W-1:0]   o_rem,
`endif
  input  logic [W-1:0]   i_a,
  input  logic [W-1:0]   i_b,
  output logic [2*W-1:0] o_prod,
  output logic           o_last
);

  localparam int CNT_W = $clog2(W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(W - 1);
`ifdef HILO_DIV_EN
  localparam int SUM_W = W + 2;
`else
  localparam int SUM_W = W + 1;
`endif

  // {r_acc, r_q} is the product register in mul mode, {remainder, dividend/quotient} in div mode.
  logic [W-1:0]     r_acc;
  logic [W-1:0]     r_q;
  logic [W-1:0]     r_b;
  logic [CNT_W-1:0] r_cnt;
`ifdef HILO_DIV_EN
  logic             r_div;
`endif

  logic [W:0]       w_opa;
  logic [W:0]       w_opb;
  logic             w_cin;
  logic [SUM_W-1:0] w_sum;
  logic [W-1:0]     w_acc_nxt;
  logic [W-1:0]     w_q_nxt;

  // Divide reuses the adder as a subtractor: shifted + ~b + 1, carry-out means no borrow.
  always_comb begin
    w_opa = {1'b0, r_acc};
    w_opb = r_q[0] ? {1'b0, r_b} : '0;
    w_cin = 1'b0;
`ifdef HILO_DIV_EN
    if (r_div) begin
      w_opa = {r_acc, r_q[W-1]};
      w_opb = ~{1'b0, r_b};
      w_cin = 1'b1;
    end
`endif
  end

  assign w_sum = SUM_W'(w_opa) + SUM_W'(w_opb) + SUM_W'(w_cin);

  always_comb begin
    {w_acc_nxt, w_q_nxt} = {w_sum[W:0], r_q[W-1:1]};
`ifdef HILO_DIV_EN
    if (r_div) begin
      w_acc_nxt = w_sum[W+1] ? w_sum[W-1:0] : {r_acc[W-2:0], r_q[W-1]};
      w_q_nxt   = {r_q[W-2:0], w_sum[W+1]};
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc <= '0;
      r_q   <= '0;
      r_b   <= '0;
      r_cnt <= '0;
`ifdef HILO_DIV_EN
      r_div <= 1'b0;
`endif
    end else if (i_start) begin
      r_acc <= '0;
      r_q   <= i_a;
      r_b   <= i_b;
      r_cnt <= '0;
`ifdef HILO_DIV_EN
      r_div <= i_mode;
`endif
    end else if (i_step) begin
      r_acc <= w_acc_nxt;
      r_q   <= w_q_nxt;
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_prod = {r_acc, r_q};
  assign o_last = (r_cnt == CNT_LAST);
`ifdef HILO_DIV_EN
  assign o_quot = r_q;
  assign o_rem  = r_acc;
`endif

endmodule

// File: rtl/hilo_unit.sv
// HI/LO register owner: MULT/MULTU/DIV/DIVU via a shared iterative core, MTHI/MTLO, MFHI/MFLO reads.
// Define HILO_DIV_EN to build the divider; otherwise DIV/DIVU are reported as illegal ops.
module hilo_unit
  import hilo_pkg::*;
#(
  parameter int DATA_W = HILO_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  // Handshake: a request transfers on a rising edge where req_valid && req_ready; the requester
  // holds req_op/req_a/req_b stable while req_valid is high and req_ready is low.
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_op,
  input  logic [DATA_W-1:0] req_a,
  input  logic [DATA_W-1:0] req_b,
  input  logic              rd_en,
  input  logic              rd_sel,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_stall,
  output logic              busy,
  output logic              done,
  output logic              div_by_zero,
  output logic              illegal_op,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo,
  output hilo_state_e       dbg_state
);

  hilo_state_e r_state;
  hilo_state_e w_state_nxt;

  logic [DATA_W-1:0]   r_hi;
  logic [DATA_W-1:0]   r_lo;
  logic                r_neg;
  logic                r_done;
  logic                r_dbz;
  logic                r_ill;

  logic                w_accept;
  logic                w_op_mul;
  logic                w_op_mt;
  logic                w_illegal;
  logic                w_signed;
  logic                w_start;
  logic                w_step;
  logic                w_last;
  logic [DATA_W-1:0]   w_abs_a;
  logic [DATA_W-1:0]   w_abs_b;
  logic [2*DATA_W-1:0] w_prod;
  logic [2*DATA_W-1:0] w_prod_fix;
`ifdef HILO_DIV_EN
  logic                r_is_div;
  logic                r_rem_neg;
  logic                w_op_div;
  logic                w_div_zero;
  logic [DATA_W-1:0]   w_quot;
  logic [DATA_W-1:0]   w_rem;
  logic [DATA_W-1:0]   w_quot_fix;
  logic [DATA_W-1:0]   w_rem_fix;
`endif

  assign w_accept = req_valid && req_ready;
  assign w_op_mul = hilo_op_mul(req_op);
  assign w_op_mt  = hilo_op_mt(req_op);
  assign w_signed = hilo_op_signed(req_op);
  // Negating the most negative value yields the same bits, which is the correct unsigned magnitude.
  assign w_abs_a  = (w_signed && req_a[DATA_W-1]) ? -req_a : req_a;
  assign w_abs_b  = (w_signed && req_b[DATA_W-1]) ? -req_b : req_b;

`ifdef HILO_DIV_EN
  assign w_op_div   = (req_op == HILO_OP_DIV) || (req_op == HILO_OP_DIVU);
  assign w_div_zero = w_op_div && (req_b == '0);
  assign w_illegal  = !(w_op_mul || w_op_div || w_op_mt);
  assign w_start    = w_accept && (w_op_mul || (w_op_div && !w_div_zero));
`else
  assign w_illegal  = !(w_op_mul || w_op_mt);
  assign w_start    = w_accept && w_op_mul;
`endif

  hilo_iter_core #(
    .W (DATA_W)
  ) u_core (
    .clk     (clk),
    .rst     (rst),
    .i_start (w_start),
    .i_step  (w_step),
`ifdef HILO_DIV_EN
    .i_mode  (w_op_div),
    .o_quot  (w_quot),
    .o_rem   (w_rem),
`endif
    .i_a     (w_abs_a),
    .i_b     (w_abs_b),
    .o_prod  (w_prod),
    .o_last  (w_last)
  );

  // FSM: state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM: next state
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept && w_op_mul) begin
          w_state_nxt = S_MUL;
        end
`ifdef HILO_DIV_EN
        if (w_accept && w_op_div && !w_div_zero) begin
          w_state_nxt = S_DIV;
        end
`endif
      end
      S_MUL: begin
        if (w_last) begin
          w_state_nxt = S_FIX;
        end
      end
`ifdef HILO_DIV_EN
      S_DIV: begin
        if (w_last) begin
          w_state_nxt = S_FIX;
        end
      end
`endif
      S_FIX:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    req_ready = (r_state == S_IDLE);
    busy      = (r_state != S_IDLE);
    rd_stall  = rd_en && busy;
    w_step    = (r_state == S_MUL) || (r_state == S_DIV);
  end

  assign w_prod_fix = r_neg ? -w_prod : w_prod;
`ifdef HILO_DIV_EN
  assign w_quot_fix = r_neg ? -w_quot : w_quot;
  assign w_rem_fix  = r_rem_neg ? -w_rem : w_rem;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hi      <= '0;
      r_lo      <= '0;
      r_neg     <= 1'b0;
      r_done    <= 1'b0;
      r_dbz     <= 1'b0;
      r_ill     <= 1'b0;
`ifdef HILO_DIV_EN
      r_is_div  <= 1'b0;
      r_rem_neg <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      r_dbz  <= 1'b0;
      r_ill  <= 1'b0;
      if (w_accept) begin
        r_neg <= w_signed && (req_a[DATA_W-1] ^ req_b[DATA_W-1]);
        if (req_op == HILO_OP_MTHI) begin
          r_hi <= req_a;
        end
        if (req_op == HILO_OP_MTLO) begin
          r_lo <= req_a;
        end
        if (w_illegal) begin
          r_ill <= 1'b1;
        end
`ifdef HILO_DIV_EN
        r_is_div  <= w_op_div;
        r_rem_neg <= w_signed && req_a[DATA_W-1];
        if (w_div_zero) begin
          r_dbz  <= 1'b1;
          r_done <= 1'b1;
        end
`endif
      end
      if (r_state == S_FIX) begin
        r_done <= 1'b1;
`ifdef HILO_DIV_EN
        if (r_is_div) begin
          r_lo <= w_quot_fix;
          r_hi <= w_rem_fix;
        end else
`endif
        begin
          r_hi <= w_prod_fix[2*DATA_W-1:DATA_W];
          r_lo <= w_prod_fix[DATA_W-1:0];
        end
      end
    end
  end

  assign hi          = r_hi;
  assign lo          = r_lo;
  assign rd_data     = rd_sel ? r_lo : r_hi;
  assign done        = r_done;
  assign div_by_zero = r_dbz;
  assign illegal_op  = r_ill;
  assign dbg_state   = r_state;

endmodule

// File: tb/tb_hilo_unit.sv
// Self-checking bench for hilo_unit: directed vector table, hand-written corner sequences,
// and random operations checked against an arithmetic reference model.
module tb_hilo_unit;
  import hilo_pkg::*;

  localparam int W   = 32;
  localparam int LAT = W + 1;
  localparam int WIN = 36;
`ifdef HILO_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid;
  logic          req_ready;
  logic [2:0]    req_op;
  logic [W-1:0]  req_a;
  logic [W-1:0]  req_b;
  logic          rd_en;
  logic          rd_sel;
  logic [W-1:0]  rd_data;
  logic          rd_stall;
  logic          busy;
  logic          done;
  logic          div_by_zero;
  logic          illegal_op;
  logic [W-1:0]  hi;
  logic [W-1:0]  lo;
  hilo_state_e   dbg_state;

  int n_checks = 0;
  int n_errors = 0;

  logic [2*W-1:0] exp_q[$];
  logic [W-1:0]   m_hi, m_lo;

  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp_hi;
    logic [W-1:0] exp_lo;
  } vec_t;
  vec_t vecs[12];

  hilo_unit #(.DATA_W(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_op      (req_op),
    .req_a       (req_a),
    .req_b       (req_b),
    .rd_en       (rd_en),
    .rd_sel      (rd_sel),
    .rd_data     (rd_data),
    .rd_stall    (rd_stall),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero),
    .illegal_op  (illegal_op),
    .hi          (hi),
    .lo          (lo),
    .dbg_state   (dbg_state)
  );

  // Clock / reset
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", n_checks, n_errors);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Reference model: architectural effect of one op on {hi, lo}.
  function automatic logic [2*W-1:0] model(input logic [2:0] op, input logic [W-1:0] a, b,
                                           input logic [W-1:0] cur_hi, cur_lo);
    longint sa, sb, q, r;
    logic [2*W-1:0] res;
    res = {cur_hi, cur_lo};
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    case (op)
      3'd0: res = 64'(sa * sb);
      3'd1: res = {32'd0, a} * {32'd0, b};
      3'd2, 3'd3: begin
        if (DIV_EN && b != 0) begin
          if (op == 3'd3) begin
            sa = longint'({32'd0, a});
            sb = longint'({32'd0, b});
          end
          q   = sa / sb;
          r   = sa % sb;
          res = {r[31:0], q[31:0]};
        end
      end
      3'd4: res[63:32] = a;
      3'd5: res[31:0]  = a;
      default: ;
    endcase
    return res;
  endfunction

  function automatic void exp_flags(input logic [2:0] op, input logic [W-1:0] b,
                                    output int e_done, e_first, e_dbz, e_ill);
    e_done = 0; e_first = -1; e_dbz = 0; e_ill = 0;
    if (op <= 3'd1) begin
      e_done = 1; e_first = LAT;
    end else if (op <= 3'd3) begin
      if (!DIV_EN) e_ill = 1;
      else if (b == 0) begin e_done = 1; e_first = 0; e_dbz = 1; end
      else begin e_done = 1; e_first = LAT; end
    end else if (op >= 3'd6) begin
      e_ill = 1;
    end
  endfunction

  // Driver: issue one request, then watch a fixed window of cycles after the accept edge.
  task automatic run_op(input logic [2:0] op, input logic [W-1:0] a, b,
                        output logic [W-1:0] o_hi, o_lo,
                        output int n_done, first_done, n_dbz, n_ill);
    int guard;
    @(negedge clk);
    guard = 0;
    while (!req_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    chk("ready before issue", 64'(req_ready), 64'd1);
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b;
    @(negedge clk);
    req_valid = 1'b0;
    n_done = 0; first_done = -1; n_dbz = 0; n_ill = 0;
    for (int n = 0; n < WIN; n++) begin
      if (n > 0) @(negedge clk);
      if (done) begin
        if (first_done < 0) first_done = n;
        n_done++;
      end
      if (div_by_zero) n_dbz++;
      if (illegal_op) n_ill++;
    end
    o_hi = hi; o_lo = lo;
  endtask

  task automatic check_op(input string tag, input logic [2:0] op, input logic [W-1:0] a, b,
                          input logic [W-1:0] e_hi, e_lo);
    logic [W-1:0] g_hi, g_lo;
    int g_done, g_first, g_dbz, g_ill;
    int e_done, e_first, e_dbz, e_ill;
    exp_flags(op, b, e_done, e_first, e_dbz, e_ill);
    run_op(op, a, b, g_hi, g_lo, g_done, g_first, g_dbz, g_ill);
    chk({tag, " hi"}, 64'(g_hi), 64'(e_hi));
    chk({tag, " lo"}, 64'(g_lo), 64'(e_lo));
    chk({tag, " done count"}, 64'(g_done), 64'(e_done));
    chk({tag, " done cycle"}, 64'(g_first), 64'(e_first));
    chk({tag, " div_by_zero count"}, 64'(g_dbz), 64'(e_dbz));
    chk({tag, " illegal_op count"}, 64'(g_ill), 64'(e_ill));
  endtask

  initial begin
    logic [2:0]     op;
    logic [W-1:0]   a, b;
    logic [2*W-1:0] e;
    int             stall_cnt, ready_cnt, done_seen;

    vecs[0] = '{HILO_OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
    vecs[1] = '{HILO_OP_MULT,  32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFEB};
`ifdef HILO_DIV_EN
    vecs[2] = '{HILO_OP_DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vecs[3] = '{HILO_OP_DIVU,  32'd7,         32'd0,         32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vecs[4] = '{HILO_OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
    vecs[5] = '{HILO_OP_MTHI,  32'h1234_5678, 32'd0,         32'h1234_5678, 32'h8000_0000};
    vecs[6] = '{3'd7,          32'd1,         32'd1,         32'h1234_5678, 32'h8000_0000};
`else
    vecs[2] = '{HILO_OP_DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFEB};
    vecs[3] = '{HILO_OP_DIVU,  32'd7,         32'd0,         32'hFFFF_FFFF, 32'hFFFF_FFEB};
    vecs[4] = '{HILO_OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFEB};
    vecs[5] = '{HILO_OP_MTHI,  32'h1234_5678, 32'd0,         32'h1234_5678, 32'hFFFF_FFEB};
    vecs[6] = '{3'd7,          32'd1,         32'd1,         32'h1234_5678, 32'hFFFF_FFEB};
`endif
    vecs[7] = '{HILO_OP_MULT,  32'd0,         32'd5,         32'h0000_0000, 32'h0000_0000};
    vecs[8] = '{HILO_OP_MULTU, 32'h8000_0000, 32'd2,         32'h0000_0001, 32'h0000_0000};
    vecs[9] = '{HILO_OP_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
`ifdef HILO_DIV_EN
    vecs[10] = '{HILO_OP_DIVU, 32'd100,       32'd7,         32'h0000_0002, 32'h0000_000E};
    vecs[11] = '{HILO_OP_DIV,  32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD};
`else
    vecs[10] = '{HILO_OP_DIVU, 32'd100,       32'd7,         32'h4000_0000, 32'h0000_0000};
    vecs[11] = '{HILO_OP_DIV,  32'd7,         32'hFFFF_FFFE, 32'h4000_0000, 32'h0000_0000};
`endif

    // Reset state
    rst = 1'b1; req_valid = 1'b0; req_op = '0; req_a = '0; req_b = '0;
    rd_en = 1'b1; rd_sel = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset hi", 64'(hi), 64'd0);
    chk("reset lo", 64'(lo), 64'd0);
    chk("reset req_ready", 64'(req_ready), 64'd1);
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset done", 64'(done), 64'd0);
    chk("reset div_by_zero", 64'(div_by_zero), 64'd0);
    chk("reset illegal_op", 64'(illegal_op), 64'd0);
    chk("reset rd_stall", 64'(rd_stall), 64'd0);
    chk("reset state", 64'(dbg_state), 64'(S_IDLE));
    rd_en = 1'b0;

    // Directed vector table
    for (int i = 0; i < 12; i++) begin
      check_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
               vecs[i].exp_hi, vecs[i].exp_lo);
      if (i == 1) begin
        rd_en = 1'b1; rd_sel = 1'b1;
        #1;
        chk("mflo data", 64'(rd_data), 64'hFFFF_FFEB);
        chk("mflo stall", 64'(rd_stall), 64'd0);
        rd_en = 1'b0;
      end
    end
    m_hi = vecs[11].exp_hi;
    m_lo = vecs[11].exp_lo;

    // Read during busy stalls every busy cycle; a second request waits until IDLE.
    @(negedge clk);
    req_valid = 1'b1; req_op = HILO_OP_MULT; req_a = 32'd5; req_b = 32'd6;
    @(negedge clk);
    req_op = HILO_OP_MTLO; req_a = 32'hDEAD_BEEF; req_b = '0;
    rd_en = 1'b1; rd_sel = 1'b0;
    stall_cnt = 0; ready_cnt = 0;
    for (int n = 0; n < LAT; n++) begin
      if (n > 0) @(negedge clk);
      #1;
      if (rd_stall) stall_cnt++;
      if (req_ready) ready_cnt++;
    end
    chk("busy stall cycles", 64'(stall_cnt), 64'(LAT));
    chk("ready while busy", 64'(ready_cnt), 64'd0);
    @(negedge clk);
    rd_sel = 1'b1;
    #1;
    chk("done-cycle read data", 64'(rd_data), 64'd30);
    chk("done-cycle stall", 64'(rd_stall), 64'd0);
    chk("done-cycle done", 64'(done), 64'd1);
    chk("done-cycle ready", 64'(req_ready), 64'd1);
    @(negedge clk);
    chk("held mtlo lands", 64'(lo), 64'hDEAD_BEEF);
    chk("held mtlo hi", 64'(hi), 64'd0);
    chk("held mtlo no busy", 64'(busy), 64'd0);
    chk("held mtlo no done", 64'(done), 64'd0);
    req_valid = 1'b0; rd_en = 1'b0;
    m_hi = 32'd0; m_lo = 32'hDEAD_BEEF;

    // Back-to-back MTHI / MTLO
    @(negedge clk);
    req_valid = 1'b1; req_op = HILO_OP_MTHI; req_a = 32'h1234_5678;
    @(negedge clk);
    chk("mthi lands", 64'(hi), 64'h1234_5678);
    chk("mthi ready", 64'(req_ready), 64'd1);
    req_op = HILO_OP_MTLO; req_a = 32'h9ABC_DEF0;
    @(negedge clk);
    chk("mtlo lands", 64'(lo), 64'h9ABC_DEF0);
    chk("mtlo keeps hi", 64'(hi), 64'h1234_5678);
    chk("mtlo ready", 64'(req_ready), 64'd1);
    chk("mt no busy", 64'(busy), 64'd0);
    req_valid = 1'b0;
    @(negedge clk);
    chk("mt no done", 64'(done), 64'd0);

    // Reset in the middle of an iterative op
    @(negedge clk);
`ifdef HILO_DIV_EN
    req_op = HILO_OP_DIVU;
`else
    req_op = HILO_OP_MULTU;
`endif
    req_valid = 1'b1; req_a = 32'd1000; req_b = 32'd3;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (10) @(negedge clk);
    chk("busy before abort", 64'(busy), 64'd1);
    rst = 1'b1;
    #1;
    chk("abort hi", 64'(hi), 64'd0);
    chk("abort lo", 64'(lo), 64'd0);
    chk("abort ready", 64'(req_ready), 64'd1);
    chk("abort state", 64'(dbg_state), 64'(S_IDLE));
    @(negedge clk);
    rst = 1'b0;
    done_seen = 0;
    for (int n = 0; n < WIN; n++) begin
      @(negedge clk);
      if (done) done_seen++;
    end
    chk("abort no done", 64'(done_seen), 64'd0);
    chk("abort hi stays", 64'(hi), 64'd0);
    m_hi = '0; m_lo = '0;

    // Random operations against the reference model
    for (int i = 0; i < 30; i++) begin
      op = 3'($urandom_range(0, 7));
      a  = $urandom;
      b  = $urandom;
      case ($urandom_range(0, 5))
        0: b = '0;
        1: a = 32'h8000_0000;
        2: b = 32'hFFFF_FFFF;
        3: a = 32'($urandom_range(0, 20));
        default: ;
      endcase
      exp_q.push_back(model(op, a, b, m_hi, m_lo));
      e = exp_q.pop_front();
      check_op($sformatf("rnd%0d op%0d", i, op), op, a, b, e[63:32], e[31:0]);
      m_hi = e[63:32];
      m_lo = e[31:0];
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
